// File: rtl/hwgq_skewed_quantizer_pkg.sv
// hwgq shared types and helpers: FSM state, tap geometry, saturation.
// Imported by the quantizer top and its per-channel slices.
package hwgq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int tap(int c, int lanes, int stride);
    return (c % lanes) * stride + c / lanes;
  endfunction

  function automatic int max_tap(int lanes, int rows, int stride);
    return (lanes - 1) * stride + rows - 1;
  endfunction

  function automatic longint saturate(longint v, logic signed_mode,
                                      int out_w);
    longint one;
    longint lo;
    longint hi;
    one = 1;
    if (signed_mode) begin
      hi = (one << (out_w - 1)) - 1;
      lo = -(one << (out_w - 1));
    end else begin
      hi = (one << out_w) - 1;
      lo = 0;
    end
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/hwgq_skewed_quantizer_if.sv
// Frame handshake, config, serial data and quantized result bundle.
// master drives the frame, slave is the quantizer.
interface hwgq_skewed_quantizer_if #(
  parameter int NUM_CH  = 8,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5
);
  logic                    start;
  logic                    abort;
  logic [SHIFT_W-1:0]      q_shift;
  logic                    signed_mode;
  logic                    round_en;
  logic [NUM_CH-1:0]       data_in;
  logic                    busy;
  logic                    done;
  logic [NUM_CH-1:0]       out_valid;
  logic [OUT_W*NUM_CH-1:0] output_array;

  modport master (
    output start, abort, q_shift, signed_mode, round_en, data_in,
    input  busy, done, out_valid, output_array
  );

  modport slave (
    input  start, abort, q_shift, signed_mode, round_en, data_in,
    output busy, done, out_valid, output_array
  );
endinterface

// File: rtl/hwgq_skewed_quantizer_channel.sv
// One channel: LSB-first serial accumulator, bit counter,
// round/shift/saturate and the held output register.
module hwgq_channel
  import hwgq_pkg::*;
#(
  parameter int ACC_W   = 24,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = $clog2(ACC_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               tok,
  input  logic               din,
  input  logic [SHIFT_W-1:0] q_shift,
  input  logic               signed_mode,
  input  logic               round_en,
  output logic               valid,
  output logic [OUT_W-1:0]   q
);
  localparam int CW = $clog2(ACC_W + 1);

  // Only ACC_W-1 bits are stored; the last bit joins from din.
  logic [ACC_W-2:0]        acc;
  logic [ACC_W-1:0]        acc_n;
  logic [CW-1:0]           cnt;
  logic                    active;
  logic signed [ACC_W+1:0] rnd;
  logic signed [ACC_W+1:0] v;
  logic signed [ACC_W+1:0] sh;

  always_comb begin
    acc_n = {din, acc};
    rnd   = '0;
    if (round_en && q_shift != '0)
      rnd = (ACC_W+2)'(1) << (q_shift - 1'b1);
    v  = $signed({{2{acc_n[ACC_W-1]}}, acc_n}) + rnd;
    sh = v >>> q_shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      cnt    <= '0;
      active <= 1'b0;
      valid  <= 1'b0;
      q      <= '0;
    end else begin
      valid <= 1'b0;
      if (clr) begin
        active <= 1'b0;
        cnt    <= '0;
      end else if (tok) begin
        acc    <= acc_n[ACC_W-1:1];
        cnt    <= CW'(1);
        active <= 1'b1;
      end else if (active) begin
        acc <= acc_n[ACC_W-1:1];
        if (cnt == CW'(ACC_W - 1)) begin
          active <= 1'b0;
          valid  <= 1'b1;
          q      <= OUT_W'(saturate(longint'(sh), signed_mode, OUT_W));
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/hwgq_skewed_quantizer.sv
// Skewed bit-serial activation quantizer array: frame FSM, token
// chain matching the PE drain diagonal, and NUM_CH channel slices.
module hwgq_skewed_quantizer
  import hwgq_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int ROWS        = 2,
  parameter int SKEW_STRIDE = 8,
  parameter int ACC_W       = 24,
  parameter int OUT_W       = 8,
  parameter int SHIFT_W     = $clog2(ACC_W)
) (
  input logic                   clk,
  input logic                   reset,
  hwgq_skewed_quantizer_if.slave bus
);
  localparam int NUM_CH  = LANES * ROWS;
  localparam int MAX_TAP = max_tap(LANES, ROWS, SKEW_STRIDE);
  localparam int FRAME   = MAX_TAP + ACC_W;
  localparam int CW      = $clog2(FRAME + 1);

  if (ROWS > SKEW_STRIDE) begin : g_bad_geom
    $error("hwgq: ROWS must not exceed SKEW_STRIDE");
  end

  state_t                  state;
  state_t                  state_n;
  logic                    load;
  logic [MAX_TAP:0]        tok;
  logic [CW-1:0]           cyc;
  logic                    done_q;
  logic [SHIFT_W-1:0]      q_shift_r;
  logic                    sm_r;
  logic                    rnd_r;
  logic [NUM_CH-1:0]       vld;
  logic [OUT_W*NUM_CH-1:0] qarr;

  assign load = (state == IDLE) && bus.start && !bus.abort;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (load) state_n = RUN;
      RUN:     if (bus.abort || done_q) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tok       <= '0;
      cyc       <= '0;
      done_q    <= 1'b0;
      q_shift_r <= '0;
      sm_r      <= 1'b0;
      rnd_r     <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= 1'b0;
      if (bus.abort) tok <= '0;
      else           tok <= (MAX_TAP+1)'({tok, load});
      if (load) begin
        cyc       <= '0;
        q_shift_r <= bus.q_shift;
        sm_r      <= bus.signed_mode;
        rnd_r     <= bus.round_en;
      end else if (state == RUN) begin
        cyc <= cyc + 1'b1;
      end
      // Lands in the same cycle as the last channel's out_valid.
      if (state == RUN && !bus.abort && cyc == CW'(FRAME - 1))
        done_q <= 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int TAP = tap(c, LANES, SKEW_STRIDE);
    hwgq_channel #(
      .ACC_W  (ACC_W),
      .OUT_W  (OUT_W),
      .SHIFT_W(SHIFT_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .clr        (bus.abort),
      .tok        (tok[TAP]),
      .din        (bus.data_in[c]),
      .q_shift    (q_shift_r),
      .signed_mode(sm_r),
      .round_en   (rnd_r),
      .valid      (vld[c]),
      .q          (qarr[OUT_W*c +: OUT_W])
    );
  end

  assign bus.busy         = (state == RUN);
  assign bus.done         = done_q;
  assign bus.out_valid    = vld;
  assign bus.output_array = qarr;
endmodule

// File: tb/tb_hwgq_skewed_quantizer.sv
// Bench for hwgq_skewed_quantizer: table vectors, random frames against
// an arithmetic model, abort/reset/restart corners, small geometry.
module tb_hwgq_skewed_quantizer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hwgq_skewed_quantizer_if #(.NUM_CH(8), .OUT_W(8), .SHIFT_W(5)) bus0 ();
  hwgq_skewed_quantizer_if #(.NUM_CH(6), .OUT_W(8), .SHIFT_W(4)) bus1 ();

  hwgq_skewed_quantizer #(
    .LANES(4), .ROWS(2), .SKEW_STRIDE(8), .ACC_W(24), .OUT_W(8), .SHIFT_W(5)
  ) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  hwgq_skewed_quantizer #(
    .LANES(2), .ROWS(3), .SKEW_STRIDE(4), .ACC_W(16), .OUT_W(8), .SHIFT_W(4)
  ) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] exp0[8];
  logic [7:0] exp1[6];

  typedef struct {
    longint     val;
    int         sh;
    bit         sm;
    bit         rnd;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(string nm, int k, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s k=%0d: got %h want %h", nm, k, act, exp);
  endtask

  function automatic int tap0(int c);
    return (c % 4) * 8 + c / 4;
  endfunction

  function automatic int tap1(int c);
    return (c % 2) * 4 + c / 2;
  endfunction

  // Round half-up, floor-divide by 2^sh, clamp to 8-bit range.
  function automatic logic [7:0] ref_q(longint val, int sh, bit sm, bit rnd);
    longint v, d, q, lo, hi;
    v = val;
    if (rnd && sh > 0) v += longint'(1) << (sh - 1);
    d = longint'(1) << sh;
    q = v / d;
    if (v < 0 && (v % d) != 0) q -= 1;
    lo = sm ? -128 : 0;
    hi = sm ? 127 : 255;
    if (q < lo) q = lo;
    if (q > hi) q = hi;
    return 8'(q);
  endfunction

  function automatic logic [63:0] pack0();
    logic [63:0] p;
    p = '0;
    for (int c = 0; c < 8; c++) p[8*c +: 8] = exp0[c];
    return p;
  endfunction

  function automatic logic [63:0] pack1();
    logic [63:0] p;
    p = '0;
    for (int c = 0; c < 6; c++) p[8*c +: 8] = exp1[c];
    return p;
  endfunction

  // kind: 0 normal, 1 abort at cycle cut, 2 reset at cycle cut.
  task automatic frame0(input longint vals[8], input logic [7:0] ex[8],
                        input int sh, input bit sm, input bit rnd,
                        input int kind, input int cut, input bit pulses);
    bit alive;
    int i;
    logic [7:0] vexp;
    @(negedge clk);
    bus0.start = 1'b1;
    bus0.abort = 1'b0;
    bus0.q_shift = 5'(sh);
    bus0.signed_mode = sm;
    bus0.round_en = rnd;
    for (int c = 0; c < 8; c++) bus0.data_in[c] = 1'($urandom);
    for (int k = 1; k <= 55; k++) begin
      @(negedge clk);
      alive = (kind == 0) || (k <= cut);
      bus0.start = pulses && (k == 10 || k == 50);
      bus0.abort = (kind == 1) && (k == cut);
      reset = (kind == 2) && (k == cut);
      if (kind == 2 && k == cut + 1) begin
        for (int c = 0; c < 8; c++) exp0[c] = '0;
        for (int c = 0; c < 6; c++) exp1[c] = '0;
      end
      vexp = '0;
      for (int c = 0; c < 8; c++) begin
        i = k - 1 - tap0(c);
        bus0.data_in[c] = (i >= 0 && i < 24) ? 1'(vals[c] >> i)
                                             : 1'($urandom);
        if (alive && i == 24) begin
          vexp[c] = 1'b1;
          exp0[c] = ex[c];
        end
      end
      chk("ctl0", k, {bus0.busy, bus0.done, bus0.out_valid},
          {alive && k <= 50, kind == 0 && k == 50, vexp});
      chk("out0", k, bus0.output_array, pack0());
    end
    bus0.start = 1'b0;
    bus0.abort = 1'b0;
    reset = 1'b0;
  endtask

  task automatic frame1(input longint vals[6], input int sh,
                        input bit sm, input bit rnd);
    int i;
    logic [5:0] vexp;
    @(negedge clk);
    bus1.start = 1'b1;
    bus1.abort = 1'b0;
    bus1.q_shift = 4'(sh);
    bus1.signed_mode = sm;
    bus1.round_en = rnd;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      bus1.start = (k == 23);
      vexp = '0;
      for (int c = 0; c < 6; c++) begin
        i = k - 1 - tap1(c);
        bus1.data_in[c] = (i >= 0 && i < 16) ? 1'(vals[c] >> i)
                                             : 1'($urandom);
        if (i == 16) begin
          vexp[c] = 1'b1;
          exp1[c] = ref_q(vals[c], sh, sm, rnd);
        end
      end
      chk("ctl1", k, {bus1.busy, bus1.done, bus1.out_valid},
          {k <= 23, k == 23, vexp});
      chk("out1", k, bus1.output_array, pack1());
    end
    bus1.start = 1'b0;
  endtask

  initial begin
    longint vals[8];
    longint v1[6];
    logic [7:0] ex[8];
    int sh;
    bit sm, rnd;
    bus0.start = 0; bus0.abort = 0; bus0.q_shift = 0;
    bus0.signed_mode = 0; bus0.round_en = 0; bus0.data_in = '0;
    bus1.start = 0; bus1.abort = 0; bus1.q_shift = 0;
    bus1.signed_mode = 0; bus1.round_en = 0; bus1.data_in = '0;
    for (int c = 0; c < 8; c++) exp0[c] = '0;
    for (int c = 0; c < 6; c++) exp1[c] = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst0", 0, {bus0.busy, bus0.done, bus0.out_valid, bus0.output_array},
        '0);
    chk("rst1", 0, {bus1.busy, bus1.done, bus1.out_valid, bus1.output_array},
        '0);
    reset = 1'b0;

    tbl[0] = '{10240,      11, 0, 0, 8'd5};
    tbl[1] = '{'h7FFFFF,    4, 0, 0, 8'd255};
    tbl[2] = '{-4096,       4, 0, 0, 8'd0};
    tbl[3] = '{'h7FFFFF,    4, 1, 0, 8'h7F};
    tbl[4] = '{-4096,       4, 1, 0, 8'h80};
    tbl[5] = '{3072,       11, 0, 0, 8'd1};
    tbl[6] = '{3072,       11, 0, 1, 8'd2};
    tbl[7] = '{-3072,      11, 1, 1, 8'hFF};
    for (int t = 0; t < 8; t++) begin
      for (int c = 0; c < 8; c++) begin
        vals[c] = tbl[t].val;
        ex[c] = tbl[t].exp;
      end
      frame0(vals, ex, tbl[t].sh, tbl[t].sm, tbl[t].rnd, 0, 0, t == 0);
    end

    repeat (6) begin
      sh = $urandom_range(0, 23);
      sm = 1'($urandom);
      rnd = 1'($urandom);
      for (int c = 0; c < 8; c++) begin
        vals[c] = longint'($signed(24'($urandom)));
        ex[c] = ref_q(vals[c], sh, sm, rnd);
      end
      frame0(vals, ex, sh, sm, rnd, 0, 0, 1'b1);
    end

    for (int c = 0; c < 8; c++) begin
      vals[c] = longint'($signed(24'($urandom)));
      ex[c] = ref_q(vals[c], 3, 1'b1, 1'b0);
    end
    frame0(vals, ex, 3, 1'b1, 1'b0, 1, 20, 1'b0);
    frame0(vals, ex, 3, 1'b1, 1'b0, 0, 0, 1'b0);
    frame0(vals, ex, 3, 1'b1, 1'b0, 2, 20, 1'b0);

    repeat (4) begin
      sh = $urandom_range(0, 15);
      sm = 1'($urandom);
      rnd = 1'($urandom);
      for (int c = 0; c < 6; c++) v1[c] = longint'($signed(16'($urandom)));
      frame1(v1, sh, sm, rnd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hwgq_skewed_quantizer.md
# hwgq_skewed_quantizer

Parametrised bit-serial activation quantizer array that sits at the output edge of the systolic PE array. It receives one LSB-first two's-complement partial sum per channel over ACC_W cycles, with per-channel start times skewed by an internal token chain that matches the array's diagonal drain order. It applies ReLU or signed mode, a runtime power-of-two scale with optional rounding and saturation, and emits one OUT_W-bit activation per channel with a valid strobe. A frame-level start/busy/done handshake frames each pass.

## Interface
- LANES, 4: channels per row group; successive lanes are offset by SKEW_STRIDE cycles.
- ROWS, 2: row groups. NUM_CH = LANES*ROWS.
- SKEW_STRIDE, 8: tap spacing between lanes. Elaboration error if ROWS > SKEW_STRIDE.
- ACC_W, 24: serial accumulator width in bits.
- OUT_W, 8: quantized output width.
- SHIFT_W, $clog2(ACC_W): width of q_shift.
- clk, in, 1: single clock; everything is posedge.
- reset, in, 1: synchronous, active-high.
- start, in, 1: launches a frame; sampled only when busy=0.
- abort, in, 1: cancels the frame in flight.
- q_shift, in, SHIFT_W: right-shift amount; legal range 0..ACC_W-1; latched at start.
- signed_mode, in, 1: 0 selects ReLU/unsigned, 1 selects signed; latched at start.
- round_en, in, 1: round half-up before the shift; latched at start.
- data_in, in, NUM_CH: one serial bit per channel.
- busy, out, 1: frame in flight.
- done, out, 1: one-cycle pulse when the frame completes.
- out_valid, out, NUM_CH: one-cycle pulse per channel.
- output_array, out, OUT_W*NUM_CH: channel c occupies bits [OUT_W*(c+1)-1 : OUT_W*c].

## Operation
- Top FSM has two states, IDLE and RUN.
  - IDLE -> RUN on start=1; the config inputs are latched in the same cycle.
  - RUN -> IDLE on the cycle after done, or on abort.
- Token chain: shift register of length MAX_TAP+1, where MAX_TAP = (LANES-1)*SKEW_STRIDE + ROWS-1.
  - Bit 0 is loaded for exactly one cycle per frame.
  - Channel c is triggered by tap(c) = (c%LANES)*SKEW_STRIDE + c/LANES.
- Channel operation:
  - On token arrival, the bit counter clears and ACC_W serial bits are shifted in LSB-first: acc <= {data_in[c], acc[ACC_W-1:1]}.
  - data_in[c] is ignored outside the channel's window.
- Quantize, with all arithmetic in ACC_W+2 signed bits:
  - v = acc.
  - If round_en and q_shift>0, v += 2^(q_shift-1).
  - q = v >>> q_shift.
- Saturation:
  - Unsigned mode: q<0 -> 0; q>2^OUT_W-1 -> 2^OUT_W-1.
  - Signed mode: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1], two's complement.
- Output hold: output_array[c] holds its last value until the next update. There is no combinational path from data_in to outputs.
- Abort:
  - Clears the token chain and all channel counters; out_valid stays low.
  - No done pulse is issued; output_array holds its values.
  - busy=0 on the next cycle.
- reset: same effect as abort, and additionally output_array=0 and the latched config is cleared to 0.
- Start while busy=1, including the done cycle, is ignored.
- Abort and start in the same cycle: abort wins and start is dropped.
- q_shift >= ACC_W is out of range; the result is unspecified and verification does not drive it.

## Timing
- Reset values: busy=0, done=0, out_valid=0, output_array=0, FSM=IDLE.
- Take T0 as the cycle where start is sampled in IDLE.
- busy rises at T0+1.
- Bit i of channel c is sampled at T0+1+tap(c)+i, for i = 0..ACC_W-1.
- out_valid[c] pulses at T0+1+tap(c)+ACC_W, and output_array[c] is updated in the same cycle.
- done pulses at T0+1+MAX_TAP+ACC_W, with busy still 1. busy=0 the following cycle.
- With defaults: MAX_TAP=25, done at T0+50, and back-to-back frames can start no sooner than every 51 cycles.

## Structure
- hwgq_pkg holds:
  - the FSM state enum;
  - the function tap(c, LANES, SKEW_STRIDE);
  - the function max_tap;
  - the saturate(v, signed_mode, OUT_W) function.
- The top instantiates NUM_CH copies of the sub-module hwgq_channel, which contains the serial accumulator, bit counter, quantize/saturate logic and output register.
- The token chain and FSM stay in the top.

## Test plan
- Defaults, q_shift=11, unsigned mode, no rounding; every channel's value is 10240 -> every channel outputs 5. out_valid[0] pulses at T0+25, out_valid[7] at T0+50, done at T0+50.
- Channel 3 value 0x7FFFFF, channel 4 value -4096, q_shift=4 -> unsigned mode gives ch3=255, ch4=0; signed mode gives ch3=127, ch4=-128 (0x80).
- Value 3072, q_shift=11: round_en=0 -> 1; round_en=1 -> 2. Value -3072, signed mode, round_en=1 -> -1 (0xFF).
- Start pulsed at T0+10 and at the done cycle -> both ignored; exactly one done per accepted start.
- abort at T0+20 -> no further out_valid pulses, no done, busy=0 at T0+21, and output_array keeps the previous frame's values. reset at T0+20 -> output_array=0.
- LANES=2, ROWS=3, SKEW_STRIDE=4, ACC_W=16 -> MAX_TAP=6; channel 5 (tap 6) pulses out_valid at T0+23, and done pulses at T0+23.
